store_buffer: RTL and testbench
===============================

# store_buffer

Coalescing-free FIFO store buffer between the MEM stage and the data cache write port. Committed stores from MEM are queued here, then drained in order to the dcache when the pipeline control asserts a get. Loads in MEM snoop the buffer: a full-coverage match forwards the youngest store's data, and a partial same-line overlap is reported as a line conflict. Full, empty, snoop-hit and line-conflict flags feed the pipeline control's interlock logic.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- LINE_BYTES, 16: dcache line size in bytes; power of two, ≥4.
---
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- put_enable_i  in  1  enqueue a store this cycle.
- put_addr_i  in  32  store byte address.
- put_data_i  in  32  store value, LSB-justified register data.
- put_size_i  in  2  0=byte, 1=half, 2=word (3 reserved, treated as word).
- get_enable_i  in  1  drain request for the head entry.
- snoop_addr_i  in  32  load byte address.
- snoop_size_i  in  2  load size, same encoding as put_size_i.
- snoop_hit_o  out  1  youngest word-match entry covers all loaded bytes.
- snoop_line_conflict_o  out  1  same-line entry exists and snoop_hit_o=0.
- snoop_data_o  out  32  lane-aligned word of the hitting entry, 0 if no hit.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- dcache_wr_valid_o  out  1  head write presented to dcache.
- dcache_wr_addr_o  out  32  head word address, bits[1:0]=0.
- dcache_wr_data_o  out  32  head lane-aligned data.
- dcache_wr_be_o  out  4  head byte enables.
- dcache_wr_ready_i  in  1  dcache accepts the write this cycle.

## Operation
- Entry fields: valid, word address (addr[31:2]), 4-bit byte mask, 32-bit lane data.
- Put: mask/lanes from size and address. Byte: mask=1<<a[1:0], data replicated into lane a[1:0]. Half: mask=3<<{a[1],0}, lane a[1]. Word: mask=4'hF. Unused address low bits are ignored.
- Put while full_o=1 is dropped, even with a same-cycle pop. The pipeline control never does this; assert in simulation.
- Drain: dcache_wr_valid_o = get_enable_i && !empty_o. The head pops on valid && dcache_wr_ready_i.
- Same-cycle put+pop when not full: both take effect, and count is unchanged.
- Pointers: head and tail of log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.
- Snoop (combinational):
  - Load mask is computed like the put mask.
  - Among valid entries with equal word address, pick the youngest (closest to tail).
  - snoop_hit_o=1 iff (entry.mask & load_mask) == load_mask.
  - snoop_line_conflict_o=1 iff !snoop_hit_o and any valid entry has the same line address (addr[31:log2(LINE_BYTES)]).
- Snoop does not see a put issued in the same cycle (old state only).

## Timing
- Reset: head=tail=count=0, all valid=0. Outputs: empty_o=1, full_o=0, snoop_hit_o=0, snoop_line_conflict_o=0, snoop_data_o=0, dcache_wr_valid_o=0.
- Put latency: 1 cycle. The entry is visible to snoop, empty_o and full_o the cycle after put_enable_i.
- Drain: head write appears combinationally with get_enable_i. Pop takes effect at the edge with ready=1. The next head is presented the following cycle.
- Back-to-back drains at 1 entry/cycle while ready stays high.
- Reset mid-drain discards all entries immediately. No partial write is retried.
- full_o, empty_o, dcache_wr_* (except valid gating) and snoop outputs are purely functions of registered state plus snoop/get inputs. No input→output path exists from put_*.

## Structure
- The definitions package holds:
  - mem_size_t (BYTE/HALF/WORD)
  - sb_entry_t {valid, waddr, be, data}
  - a shared function that builds the byte mask and lane-aligned data from size/address.
- One sub-module, sb_snoop: combinational youngest-match search plus line compare over the entry array, given head/count. The FIFO storage and pointers stay in store_buffer.

## Test plan
- Reset then put word 0x1000=0xDEADBEEF, then snoop word 0x1000 → hit=1, data=0xDEADBEEF, empty_o=0 next cycle.
- Put byte 0x2003=0xAB → be=4'b1000, data=0xAB000000. Snoop half 0x2002 → hit=0, conflict=1.
- Put word 0x3000=1, then word 0x3000=2; snoop 0x3000 → data=2 (youngest). Drain with ready=1 → writes 1 then 2 on consecutive cycles.
- Fill DEPTH=4 entries → full_o=1. A fifth put plus get with ready=1 the same cycle → count=3, fifth store absent.
- get_enable_i=1, ready=0 for 3 cycles → valid held, head/address/data stable, no pop. Ready=1 → pop, count decrements.
- Snoop 0x4010 with an entry at 0x4000, LINE_BYTES=16 → conflict=0. Snoop 0x4008 → conflict=1. Assert reset mid-sequence → all flags return to reset values in the same cycle.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and the byte-lane helpers used by the store buffer
// and its snoop comparator.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;

  // Size code 3 is reserved and falls through to the word case.
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] a);
    case (mem_size_t'(size))
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic lane_t build_lanes(input logic [1:0] size, input logic [1:0] a,
                                        input logic [31:0] d);
    lane_t l;
    l.be = size_mask(size, a);
    case (mem_size_t'(size))
      SZ_BYTE: l.data = {24'd0, d[7:0]} << {a, 3'b000};
      SZ_HALF: l.data = a[1] ? {d[15:0], 16'd0} : {16'd0, d[15:0]};
      default: l.data = d;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/store_buffer_snoop.sv
// Combinational load snoop: youngest same-word entry decides hit/forward,
// any same-line entry without a hit is reported as a line conflict.
module sb_snoop
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LINE_BYTES = 16
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [31:0]                addr,
  input  logic [1:0]                 size,
  output logic                       hit,
  output logic                       line_conflict,
  output logic [31:0]                data
);

  localparam int PTR_W      = $clog2(DEPTH);
  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  logic [3:0]       load_be;
  logic [3:0]       match_be;
  logic [31:0]      match_data;
  logic             match_found;
  logic             line_any;
  logic [PTR_W-1:0] idx;

  always_comb begin
    load_be     = size_mask(size, addr[1:0]);
    match_found = 1'b0;
    match_be    = '0;
    match_data  = '0;
    line_any    = 1'b0;
    idx         = head;
    // Walk oldest to youngest so the last word match seen is the youngest.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && entries[idx].valid) begin
        if (entries[idx].waddr == addr[31:2]) begin
          match_found = 1'b1;
          match_be    = entries[idx].be;
          match_data  = entries[idx].data;
        end
        if (entries[idx].waddr[29:LINE_SHIFT-2] == addr[31:LINE_SHIFT]) begin
          line_any = 1'b1;
        end
      end
    end
    hit           = match_found && ((match_be & load_be) == load_be);
    line_conflict = !hit && line_any;
    data          = hit ? match_data : '0;
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between MEM and the dcache write port, with a
// combinational load snoop over the queued entries.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int LINE_BYTES     = 16,
  parameter bit CHECK_OVERFLOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        put_enable_i,
  input  logic [31:0] put_addr_i,
  input  logic [31:0] put_data_i,
  input  logic [1:0]  put_size_i,
  input  logic        get_enable_i,
  input  logic [31:0] snoop_addr_i,
  input  logic [1:0]  snoop_size_i,
  output logic        snoop_hit_o,
  output logic        snoop_line_conflict_o,
  output logic [31:0] snoop_data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        dcache_wr_valid_o,
  output logic [31:0] dcache_wr_addr_o,
  output logic [31:0] dcache_wr_data_o,
  output logic [3:0]  dcache_wr_be_o,
  input  logic        dcache_wr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        entries [DEPTH];
  sb_entry_t        put_entry;
  lane_t            put_lanes;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             full, empty, push, pop;

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A put while full is dropped even if the head pops in the same cycle.
  assign push = put_enable_i && !full;
  assign pop  = dcache_wr_valid_o && dcache_wr_ready_i;

  always_comb begin
    put_lanes       = build_lanes(put_size_i, put_addr_i[1:0], put_data_i);
    put_entry.valid = 1'b1;
    put_entry.waddr = put_addr_i[31:2];
    put_entry.be    = put_lanes.be;
    put_entry.data  = put_lanes.data;
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push) tail_next = tail_reg + 1'b1;
    if (pop)  head_next = head_reg + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Push and pop never target the same slot: that needs count 0 or DEPTH.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        entries[gi] <= '0;
      end else if (push && (tail_reg == PTR_W'(gi))) begin
        entries[gi] <= put_entry;
      end else if (pop && (head_reg == PTR_W'(gi))) begin
        entries[gi].valid <= 1'b0;
      end
    end
  end

  assign full_o            = full;
  assign empty_o           = empty;
  assign dcache_wr_valid_o = get_enable_i && !empty;
  assign dcache_wr_addr_o  = {entries[head_reg].waddr, 2'b00};
  assign dcache_wr_data_o  = entries[head_reg].data;
  assign dcache_wr_be_o    = entries[head_reg].be;

  sb_snoop #(
    .DEPTH      (DEPTH),
    .LINE_BYTES (LINE_BYTES)
  ) u_snoop (
    .entries       (entries),
    .head          (head_reg),
    .count         (count_reg),
    .addr          (snoop_addr_i),
    .size          (snoop_size_i),
    .hit           (snoop_hit_o),
    .line_conflict (snoop_line_conflict_o),
    .data          (snoop_data_o)
  );

  if (CHECK_OVERFLOW) begin : g_overflow_check
    assert property (@(posedge clk_i) disable iff (reset_i) !(put_enable_i && full))
      else $error("store_buffer: put while full was dropped");
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer: expected dcache writes are queued at
// put time and compared as the DUT drains them; snoop/flag checks are inline.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        put_enable_i = 1'b0;
  logic [31:0] put_addr_i = '0;
  logic [31:0] put_data_i = '0;
  logic [1:0]  put_size_i = '0;
  logic        get_enable_i = 1'b0;
  logic [31:0] snoop_addr_i = '0;
  logic [1:0]  snoop_size_i = 2'd2;
  logic        snoop_hit_o, snoop_line_conflict_o;
  logic [31:0] snoop_data_o;
  logic        full_o, empty_o;
  logic        dcache_wr_valid_o;
  logic [31:0] dcache_wr_addr_o, dcache_wr_data_o;
  logic [3:0]  dcache_wr_be_o;
  logic        dcache_wr_ready_i = 1'b0;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  writes = 0;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH(4), .LINE_BYTES(16), .CHECK_OVERFLOW(1'b0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .put_enable_i(put_enable_i), .put_addr_i(put_addr_i), .put_data_i(put_data_i),
    .put_size_i(put_size_i), .get_enable_i(get_enable_i),
    .snoop_addr_i(snoop_addr_i), .snoop_size_i(snoop_size_i),
    .snoop_hit_o(snoop_hit_o), .snoop_line_conflict_o(snoop_line_conflict_o),
    .snoop_data_o(snoop_data_o), .full_o(full_o), .empty_o(empty_o),
    .dcache_wr_valid_o(dcache_wr_valid_o), .dcache_wr_addr_o(dcache_wr_addr_o),
    .dcache_wr_data_o(dcache_wr_data_o), .dcache_wr_be_o(dcache_wr_be_o),
    .dcache_wr_ready_i(dcache_wr_ready_i)
  );

  function automatic wr_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr_t w;
    w.addr = {a[31:2], 2'b00};
    case (sz)
      2'd0: begin
        w.be   = 4'b0001 << a[1:0];
        w.data = {24'd0, d[7:0]} << (8 * int'(a[1:0]));
      end
      2'd1: begin
        w.be   = a[1] ? 4'b1100 : 4'b0011;
        w.data = a[1] ? (d << 16) : (d & 32'h0000_FFFF);
      end
      default: begin
        w.be   = 4'b1111;
        w.data = d;
      end
    endcase
    return w;
  endfunction

  // Settle, score any write the DUT is handing off, then advance one cycle.
  task automatic step();
    wr_t e;
    #1;
    if (dcache_wr_valid_o && dcache_wr_ready_i) begin
      writes++;
      total++;
      $display("drain addr=%h data=%h be=%b", dcache_wr_addr_o, dcache_wr_data_o, dcache_wr_be_o);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL drain_unexpected: got addr=%h data=%h, wanted no write", dcache_wr_addr_o, dcache_wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if (dcache_wr_addr_o !== e.addr || dcache_wr_data_o !== e.data || dcache_wr_be_o !== e.be) begin
          bad++;
          $display("FAIL drain_write: got %h/%h/%b wanted %h/%h/%b", dcache_wr_addr_o, dcache_wr_data_o,
                   dcache_wr_be_o, e.addr, e.data, e.be);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    put_enable_i = 1'b1;
    put_addr_i   = a;
    put_data_i   = d;
    put_size_i   = sz;
    exp_q.push_back(model(a, d, sz));
    $display("put addr=%h data=%h size=%0d", a, d, sz);
    step();
    put_enable_i = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a, input logic [1:0] sz, input logic exp_hit,
                       input logic exp_conf, input logic [31:0] exp_data);
    snoop_addr_i = a;
    snoop_size_i = sz;
    #1;
    total++;
    $display("snoop addr=%h size=%0d hit=%b conflict=%b data=%h", a, sz, snoop_hit_o,
             snoop_line_conflict_o, snoop_data_o);
    if (snoop_hit_o !== exp_hit || snoop_line_conflict_o !== exp_conf || snoop_data_o !== exp_data) begin
      bad++;
      $display("FAIL snoop_%h: got hit=%b conf=%b data=%h wanted hit=%b conf=%b data=%h", a,
               snoop_hit_o, snoop_line_conflict_o, snoop_data_o, exp_hit, exp_conf, exp_data);
    end
  endtask

  task automatic drain_all(input int n, input bit check_b2b);
    int start, cycles;
    start  = writes;
    cycles = 0;
    get_enable_i      = 1'b1;
    dcache_wr_ready_i = 1'b1;
    while (!empty_o && cycles < 20) begin
      step();
      cycles++;
    end
    get_enable_i      = 1'b0;
    dcache_wr_ready_i = 1'b0;
    total++;
    if (!empty_o || writes - start != n || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_count: got writes=%0d empty=%b left=%0d wanted writes=%0d empty=1 left=0",
               writes - start, empty_o, exp_q.size(), n);
    end
    if (check_b2b) begin
      total++;
      if (cycles != n) begin
        bad++;
        $display("FAIL back_to_back: got %0d cycles wanted %0d", cycles, n);
      end
    end
  endtask

  task automatic test_reset();
    get_enable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || dcache_wr_valid_o !== 1'b0 || snoop_hit_o !== 1'b0 ||
        snoop_line_conflict_o !== 1'b0 || snoop_data_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got empty=%b full=%b valid=%b hit=%b conf=%b data=%h wanted 1 0 0 0 0 0",
               empty_o, full_o, dcache_wr_valid_o, snoop_hit_o, snoop_line_conflict_o, snoop_data_o);
    end
    get_enable_i = 1'b0;
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_put_snoop();
    put(32'h1000, 32'hDEAD_BEEF, 2'd2);
    total++;
    if (empty_o !== 1'b0) begin
      bad++;
      $display("FAIL empty_after_put: got %b wanted 0", empty_o);
    end
    snoop(32'h1000, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF);
    snoop(32'h1002, 2'd1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    drain_all(1, 1'b1);
  endtask

  task automatic test_partial();
    put(32'h2003, 32'h0000_00AB, 2'd0);
    put(32'h2006, 32'h1234_CAFE, 2'd1);
    snoop(32'h2002, 2'd1, 1'b0, 1'b1, 32'd0);
    snoop(32'h2003, 2'd0, 1'b1, 1'b0, 32'hAB00_0000);
    snoop(32'h2004, 2'd2, 1'b0, 1'b1, 32'd0);
    snoop(32'h2007, 2'd0, 1'b1, 1'b0, 32'hCAFE_0000);
    drain_all(2, 1'b1);
  endtask

  task automatic test_youngest();
    put(32'h3000, 32'd1, 2'd2);
    put(32'h3000, 32'd2, 2'd2);
    snoop(32'h3000, 2'd2, 1'b1, 1'b0, 32'd2);
    drain_all(2, 1'b1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) put(32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 2'd2);
    total++;
    if (full_o !== 1'b1 || empty_o !== 1'b0) begin
      bad++;
      $display("FAIL full_flag: got full=%b empty=%b wanted 1 0", full_o, empty_o);
    end
    // Fifth put races a pop while full: the pop happens, the put is dropped.
    put_enable_i = 1'b1;
    put_addr_i   = 32'h5010;
    put_data_i   = 32'h99;
    put_size_i   = 2'd2;
    get_enable_i = 1'b1;
    dcache_wr_ready_i = 1'b1;
    step();
    put_enable_i = 1'b0;
    get_enable_i = 1'b0;
    dcache_wr_ready_i = 1'b0;
    total++;
    if (full_o !== 1'b0 || empty_o !== 1'b0) begin
      bad++;
      $display("FAIL full_drop: got full=%b empty=%b wanted 0 0", full_o, empty_o);
    end
    snoop(32'h5010, 2'd2, 1'b0, 1'b0, 32'd0);
    snoop(32'h5000, 2'd2, 1'b0, 1'b1, 32'd0);
    drain_all(3, 1'b1);
  endtask

  task automatic test_stall();
    put(32'h6004, 32'h1234_5678, 2'd2);
    get_enable_i = 1'b1;
    dcache_wr_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (dcache_wr_valid_o !== 1'b1 || dcache_wr_addr_o !== 32'h6004 ||
          dcache_wr_data_o !== 32'h1234_5678 || dcache_wr_be_o !== 4'hF || empty_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got v=%b a=%h d=%h be=%b empty=%b wanted 1 00006004 12345678 1111 0",
                 dcache_wr_valid_o, dcache_wr_addr_o, dcache_wr_data_o, dcache_wr_be_o, empty_o);
      end
      step();
    end
    dcache_wr_ready_i = 1'b1;
    step();
    get_enable_i = 1'b0;
    dcache_wr_ready_i = 1'b0;
    total++;
    if (empty_o !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_release: got empty=%b left=%0d wanted 1 0", empty_o, exp_q.size());
    end
  endtask

  task automatic test_put_pop();
    put(32'h7000, 32'h11, 2'd2);
    put_enable_i = 1'b1;
    put_addr_i   = 32'h7004;
    put_data_i   = 32'h22;
    put_size_i   = 2'd2;
    exp_q.push_back(model(32'h7004, 32'h22, 2'd2));
    get_enable_i = 1'b1;
    dcache_wr_ready_i = 1'b1;
    step();
    put_enable_i = 1'b0;
    get_enable_i = 1'b0;
    dcache_wr_ready_i = 1'b0;
    snoop(32'h7004, 2'd2, 1'b1, 1'b0, 32'h22);
    snoop(32'h7000, 2'd2, 1'b0, 1'b1, 32'd0);
    drain_all(1, 1'b1);
  endtask

  task automatic test_line_and_reset();
    put(32'h4000, 32'h0A0B_0C0D, 2'd2);
    snoop(32'h4010, 2'd2, 1'b0, 1'b0, 32'd0);
    snoop(32'h4008, 2'd2, 1'b0, 1'b1, 32'd0);
    snoop(32'h4000, 2'd2, 1'b1, 1'b0, 32'h0A0B_0C0D);
    put(32'h4004, 32'h77, 2'd2);
    snoop(32'h4008, 2'd2, 1'b0, 1'b1, 32'd0);
    get_enable_i = 1'b1;
    dcache_wr_ready_i = 1'b0;
    #1;
    reset_i = 1'b1;
    #1;
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || dcache_wr_valid_o !== 1'b0 || snoop_hit_o !== 1'b0 ||
        snoop_line_conflict_o !== 1'b0 || snoop_data_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_drain: got empty=%b full=%b valid=%b hit=%b conf=%b data=%h wanted 1 0 0 0 0 0",
               empty_o, full_o, dcache_wr_valid_o, snoop_hit_o, snoop_line_conflict_o, snoop_data_o);
    end
    exp_q.delete();
    step();
    reset_i = 1'b0;
    get_enable_i = 1'b0;
    step();
    snoop(32'h4000, 2'd2, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_put_snoop();
    test_partial();
    test_youngest();
    test_full();
    test_stall();
    test_put_pop();
    test_line_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
